// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Purpose:
//   Instruction prefetch front end. It issues sequential word fetches to the
//   instruction memory (one request outstanding at a time) and buffers the
//   returned words, together with their fetch address + 4, in a small
//   circular queue. The decode stage pops from the queue head. A redirect
//   flushes the queue and restarts fetching at a new address. If a request
//   is still outstanding when the redirect arrives, that response is
//   dropped when it comes back.
//
// Parameters:
//   DEPTH     - queue depth in entries (power of two, 2..16)
//   RESET_PC  - first fetch address after reset
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset
//   imem_req     out  registered memory request
//   imem_addr    out  registered word-aligned fetch address
//   imem_ack     in   memory accepts request; imem_rdata valid same cycle
//   imem_rdata   in   instruction word returned by memory
//   redirect     in   branch/jump taken: flush and restart fetch
//   redirect_pc  in   new fetch address (bits [1:0] ignored)
//   stall        in   downstream cannot accept an instruction this cycle
//   instr_valid  out  queue head holds a valid instruction
//   instr_out    out  queue head instruction (0 when not valid)
//   pc4_out      out  queue head fetch address + 4 (0 when not valid)
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Request-side state
    logic             req_q,     req_d;
    logic [31:0]      addr_q,    addr_d;
    // Address of the next word to request. While a discarded response is
    // pending this holds the redirect target rather than addr_q + 4.
    logic [31:0]      fetchPc_q, fetchPc_d;
    // Set while the outstanding request belongs to a flushed stream.
    logic             discard_q, discard_d;

    // Queue state
    logic [CNT_W-1:0] count_q,   count_d;
    logic [PTR_W-1:0] rdPtr_q,   rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q,   wrPtr_d;
    logic [31:0]      instrMem_q [DEPTH];
    logic [31:0]      pc4Mem_q   [DEPTH];

    logic             transfer;
    logic             pushEn;
    logic             popEn;
    logic [31:0]      redirectTarget;
    logic [31:0]      nextPc;
    logic             unusedPcBits;

    assign transfer       = req_q & imem_ack;
    // A word is kept only if its stream was not flushed, either earlier
    // (discard_q) or in this very cycle (redirect).
    assign pushEn         = transfer & ~discard_q & ~redirect;
    // Redirect wins over stall and flushes the head instead of popping it.
    assign popEn          = (count_q != '0) & ~stall & ~redirect;
    assign redirectTarget = {redirect_pc[31:2], 2'b00};
    assign unusedPcBits   = ^redirect_pc[1:0];

    // Queue pointer and occupancy bookkeeping. A redirect empties the queue
    // outright; otherwise push and pop each move their own pointer and only
    // an unbalanced push or pop changes the count.
    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (redirect) begin
            count_d = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({pushEn, popEn})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Request sequencing. A request, once raised, holds its address until it
    // is acked. After an ack the next request follows immediately unless the
    // queue will be full or a redirect is flushing the stream. An idle
    // requester restarts as soon as the post-edge count leaves room, which
    // is what lets a pop from a full queue restart fetching in one cycle.
    always_comb begin
        req_d     = req_q;
        addr_d    = addr_q;
        fetchPc_d = fetchPc_q;
        discard_d = discard_q;
        nextPc    = fetchPc_q;
        if (redirect) begin
            fetchPc_d = redirectTarget;
            if (req_q && !imem_ack) begin
                // Request stays on the bus at its old address; its data
                // is dropped when it finally arrives.
                discard_d = 1'b1;
            end else if (transfer) begin
                // The word arriving now is dropped; restart next cycle.
                req_d     = 1'b0;
                discard_d = 1'b0;
            end else begin
                req_d     = 1'b1;
                addr_d    = redirectTarget;
                discard_d = 1'b0;
            end
        end else if (transfer) begin
            // A discarded response resumes at the stored redirect target;
            // a kept response simply continues sequentially (32-bit wrap).
            nextPc    = discard_q ? fetchPc_q : (addr_q + 32'd4);
            fetchPc_d = nextPc;
            discard_d = 1'b0;
            if (count_d < FULL_CNT) begin
                req_d  = 1'b1;
                addr_d = nextPc;
            end else begin
                req_d  = 1'b0;
            end
        end else if (!req_q) begin
            if (count_d < FULL_CNT) begin
                req_d  = 1'b1;
                addr_d = fetchPc_q;
            end
        end
    end

    // Control state registers; reset overrides redirect, stall and any
    // response acked in the reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            fetchPc_q <= RESET_PC;
            discard_q <= 1'b0;
            count_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
        end else begin
            req_q     <= req_d;
            addr_q    <= addr_d;
            fetchPc_q <= fetchPc_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
        end
    end

    // Queue storage. Entries need no reset because the outputs are gated
    // by the occupancy count.
    always_ff @(posedge clk) begin
        if (!reset && pushEn) begin
            instrMem_q[wrPtr_q] <= imem_rdata;
            pc4Mem_q[wrPtr_q]   <= addr_q + 32'd4;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_valid ? instrMem_q[rdPtr_q] : 32'h0;
    assign pc4_out     = instr_valid ? pc4Mem_q[rdPtr_q]   : 32'h0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//
// Purpose:
//   Directed self-checking bench for fetch_prefetch_unit (DEPTH=4,
//   RESET_PC=0). The memory model returns the fetch address as the data
//   word, so every instruction identifies where it came from.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;

    int checks   = 0;
    int failures = 0;

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc4_out     (pc4_out)
    );

    // Memory returns the requested address as the instruction word.
    assign imem_rdata = imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic ack,
                                 input logic redir, input logic [31:0] rpc,
                                 input logic stl);
        reset       = rst;
        imem_ack    = ack;
        redirect    = redir;
        redirect_pc = rpc;
        stall       = stl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;

        // Streaming with ack always high and no stall
        $display("[TB] streaming fetch");
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("rst_req",   {31'h0, imem_req},    32'h0);
        checkOutput("rst_addr",  imem_addr,            32'h0);
        checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rst_instr", instr_out,            32'h0);
        checkOutput("rst_pc4",   pc4_out,              32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rel_req",   {31'h0, imem_req},    32'h1);
        checkOutput("rel_addr",  imem_addr,            32'h0);
        checkOutput("rel_valid", {31'h0, instr_valid}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("str_valid", {31'h0, instr_valid}, 32'h1);
            checkOutput("str_instr", instr_out, 32'(4 * k));
            checkOutput("str_pc4",   pc4_out,   32'(4 * k + 4));
        end

        // Fill under stall, then drain
        $display("[TB] stall fill and drain");
        applyStimulus(1, 1, 0, 0, 1);
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0, 0, 1);
        checkOutput("full_req",   {31'h0, imem_req}, 32'h0);
        checkOutput("full_instr", instr_out,         32'h0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("full_req2",  {31'h0, imem_req}, 32'h0);
        checkOutput("full_hold",  instr_out,         32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("drain_req",  {31'h0, imem_req}, 32'h1);
        checkOutput("drain_addr", imem_addr,         32'h10);
        checkOutput("drain_i1",   instr_out,         32'h4);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("drain_i", instr_out, 32'(4 * k));
        end

        // Redirect (with stall) while a request waits for ack
        $display("[TB] redirect with pending request");
        applyStimulus(1, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 1);
        checkOutput("pre_instr", instr_out, 32'h0);
        checkOutput("pre_addr",  imem_addr, 32'hC);
        applyStimulus(0, 0, 1, 32'h0000_0103, 1);
        checkOutput("rd_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rd_instr", instr_out,            32'h0);
        checkOutput("rd_req",   {31'h0, imem_req},    32'h1);
        checkOutput("rd_hold",  imem_addr,            32'hC);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rd_hold2", imem_addr,            32'hC);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rd_disc",  {31'h0, instr_valid}, 32'h0);
        checkOutput("rd_naddr", imem_addr,            32'h100);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rd_instr1", instr_out, 32'h100);
        checkOutput("rd_pc4",    pc4_out,   32'h104);

        // Redirect in the same cycle as a transfer
        $display("[TB] redirect with simultaneous ack");
        applyStimulus(1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("sc_addr",  imem_addr, 32'h10);
        applyStimulus(0, 1, 1, 32'h0000_0200, 0);
        checkOutput("sc_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("sc_req",   {31'h0, imem_req},    32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("sc_req2",  {31'h0, imem_req},    32'h1);
        checkOutput("sc_naddr", imem_addr,            32'h200);
        checkOutput("sc_empty", {31'h0, instr_valid}, 32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("sc_instr", instr_out, 32'h200);

        // Two redirects while one request is outstanding
        $display("[TB] double redirect");
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h0000_0300, 0);
        checkOutput("dr_addr1", imem_addr, 32'h4);
        applyStimulus(0, 0, 1, 32'h0000_0400, 0);
        checkOutput("dr_addr2", imem_addr, 32'h4);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("dr_naddr", imem_addr,            32'h400);
        checkOutput("dr_valid", {31'h0, instr_valid}, 32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("dr_instr", instr_out, 32'h400);
        checkOutput("dr_pc4",   pc4_out,   32'h404);

        // Reset mid-stream with two queued entries
        $display("[TB] mid-stream reset");
        applyStimulus(1, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("mr_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("mr_instr", instr_out,            32'h0);
        checkOutput("mr_req",   {31'h0, imem_req},    32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("mr_req2",  {31'h0, imem_req},    32'h1);
        checkOutput("mr_addr",  imem_addr,            32'h0);

        // Address wrap at the top of memory, unaligned redirect target
        $display("[TB] address wrap");
        applyStimulus(0, 0, 1, 32'hFFFF_FFFE, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wr_addr",  imem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wr_instr", instr_out, 32'hFFFF_FFFC);
        checkOutput("wr_pc4",   pc4_out,   32'h0);
        checkOutput("wr_naddr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
